// File: rtl/read_ptr_empty_if.sv
// rtl/read_ptr_empty_if.sv - read-side pointer/flag bundle of the async FIFO
interface read_ptr_empty_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  Rinc;
  logic [ADDR_WIDTH:0]   write_ptr_grey;
  logic [ADDR_WIDTH:0]   read_ptr_grey;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_level;
  logic                  underflow;

  // FIFO consumer / write-domain side
  modport master (
    output Rinc,
    output write_ptr_grey,
    input  read_ptr_grey,
    input  read_addr,
    input  empty,
    input  almost_empty,
    input  rd_level,
    input  underflow
  );

  // read pointer block
  modport slave (
    input  Rinc,
    input  write_ptr_grey,
    output read_ptr_grey,
    output read_addr,
    output empty,
    output almost_empty,
    output rd_level,
    output underflow
  );
endinterface

// File: rtl/read_ptr_empty.sv
// rtl/read_ptr_empty.sv - read pointer, write-pointer synchronizer and empty/level flags
module read_ptr_empty #(
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input logic              R_CLK,
  input logic              RST,
  read_ptr_empty_if.slave  rif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [PW-1:0] wq1;
  logic [PW-1:0] wq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray;
  logic [PW-1:0] level_q;
  logic          empty_q;
  logic          almost_empty_q;
  logic          underflow_q;

  logic          ren;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;

  // XOR-prefix from the MSB turns the synchronized Gray write pointer back to binary
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // next pointer values and the occupancy they leave behind; the read and any
  // newly synchronized write are folded into one compare on the same edge
  always_comb begin
    ren        = rif.Rinc & ~empty_q;
    rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, ren};
    rgray_next = rbin_next ^ (rbin_next >> 1);
    wbin_s     = gray2bin(wq2);
    level_next = wbin_s - rbin_next;
  end

  // two-flop synchronizer for the write-domain Gray pointer; only wq2 is consumed
  always_ff @(posedge R_CLK or posedge RST) begin
    if (RST) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= rif.write_ptr_grey;
      wq2 <= wq1;
    end
  end

  // read pointer (binary and Gray) and registered flags; empty compares the full
  // width so a wrap-bit difference reads as full rather than empty
  always_ff @(posedge R_CLK or posedge RST) begin
    if (RST) begin
      rbin           <= '0;
      rgray          <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      rbin           <= rbin_next;
      rgray          <= rgray_next;
      level_q        <= level_next;
      empty_q        <= (rgray_next == wq2);
      almost_empty_q <= (level_next <= AE_TH);
      underflow_q    <= rif.Rinc & empty_q;
    end
  end

  assign rif.read_ptr_grey = rgray;
  assign rif.read_addr     = rbin[ADDR_WIDTH-1:0];
  assign rif.empty         = empty_q;
  assign rif.almost_empty  = almost_empty_q;
  assign rif.rd_level      = level_q;
  assign rif.underflow     = underflow_q;

endmodule

// File: doc/read_ptr_empty.md
# read_ptr_empty

Read-side pointer and empty-flag block of the asynchronous FIFO, clocked by the read clock. It keeps the read pointer in binary and Gray form and brings the write-domain Gray pointer across with a two-flop synchronizer. From these it drives the registered `empty`, `almost_empty` and fill-level outputs and the RAM read address. It pairs with the write-side pointer block; its `read_ptr_grey` output goes to the write-domain full logic.

## Interface
- `ADDR_WIDTH`, default 4: FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
- `ALMOST_EMPTY_TH`, default 1: `almost_empty` asserts when the level is <= this value; legal range 0..2^ADDR_WIDTH-1.

- `R_CLK`  in  1  read clock; all state updates on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `Rinc`  in  1  read request; honoured only when `empty`=0.
- `write_ptr_grey`  in  ADDR_WIDTH+1  write pointer, Gray coded, from the W_CLK domain (asynchronous to R_CLK).
- `read_ptr_grey`  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- `read_addr`  out  ADDR_WIDTH  RAM read address = low ADDR_WIDTH bits of the binary read pointer.
- `empty`  out  1  registered FIFO-empty flag.
- `almost_empty`  out  1  registered; level <= ALMOST_EMPTY_TH.
- `rd_level`  out  ADDR_WIDTH+1  registered occupancy seen from the read side, 0..2^ADDR_WIDTH.
- `underflow`  out  1  one-cycle pulse: `Rinc` seen while `empty`=1.

## Operation
- Synchronizer: `wq1 <= write_ptr_grey`; `wq2 <= wq1`. Only `wq2` is used by downstream logic. No other path from `write_ptr_grey`.
- Read enable: `ren = Rinc & ~empty`.
- Binary pointer `rbin` (ADDR_WIDTH+1 bits): `rbin_next = rbin + ren`. It wraps modulo 2^(ADDR_WIDTH+1).
- Gray pointer: `rgray_next = rbin_next ^ (rbin_next >> 1)`. `read_ptr_grey` is registered from `rgray_next`, so exactly one bit changes per advance.
- Empty: `empty <= (rgray_next == wq2)`. The compare uses the full ADDR_WIDTH+1 bits, including the wrap bit.
- Level: `wbin_s = gray2bin(wq2)`, the XOR-prefix from the MSB. `rd_level <= (wbin_s - rbin_next)` mod 2^(ADDR_WIDTH+1). The value 2^ADDR_WIDTH is full and is legal.
- `almost_empty <= (wbin_s - rbin_next) <= ALMOST_EMPTY_TH`, computed from the same difference.
- Underflow: `underflow <= Rinc & empty`. The pointer does not move and no other state changes.
- `read_addr = rbin[ADDR_WIDTH-1:0]`. It is combinational from the register, so it is a registered value.

## Timing
- Reset (RST=1, asynchronous) sets:
  - `rbin`, `read_ptr_grey`, `wq1`, `wq2`, `rd_level` and `underflow` to 0;
  - `read_addr` to 0;
  - `empty` and `almost_empty` to 1.
- Reset release is synchronous in effect: the first update happens on the first R_CLK edge after RST falls.
- Write-side change to empty deassert: `write_ptr_grey` changes before edge N. `wq1` captures it at N, `wq2` at N+1, and `empty`, `rd_level` and `almost_empty` update at N+2. This latency is 3 R_CLK edges, including edge N.
- Read to flag update: on the edge where `ren`=1, the pointer, `read_ptr_grey`, `read_addr`, `empty`, `rd_level` and `almost_empty` all update together. Zero-cycle pessimism on the read side.
- Last-entry read: with level 1 and `Rinc`=1, `empty` asserts on that same edge. A further `Rinc` on the next cycle gives `underflow`=1 for one cycle, and the pointer holds.
- Simultaneous read and write-pointer arrival: both terms are folded into the same edge's compare. The level stays the same (one in, one out), and `empty` does not glitch.
- Wrap-around: `rbin` goes from 2^(ADDR_WIDTH+1)-1 to 0. The Gray pointer changes by one bit (MSB). `empty` remains correct because the full-width compare is used.
- Mid-operation reset: all outputs return to their reset values asynchronously. Any in-flight synchronizer contents are discarded.
- Pessimism: `empty` and `rd_level` may lag the true state by the synchronizer latency. They never indicate data that is not yet written.

## Test plan
- Reset: assert RST mid-traffic with level 5. Outputs go immediately to `empty`=1, `almost_empty`=1, `rd_level`=0, `read_ptr_grey`=0 and `read_addr`=0, with no R_CLK edge needed.
- Sync latency: hold `write_ptr_grey`=0, then drive 5'b00001 before edge N. `empty` falls and `rd_level`=1 after edge N+2, not earlier.
- Drain: `write_ptr_grey`=gray(3) synced, then `Rinc` for 3 cycles. `rd_level` goes 2, 1, 0; `read_addr` goes 1, 2, 3; `empty` rises on the third read edge; `almost_empty` rises when level=1.
- Underflow: `empty`=1 and `Rinc`=1 for 2 cycles. `underflow` is high for 2 cycles and `read_ptr_grey` is unchanged.
- Wrap: run 40 writes/reads with ADDR_WIDTH=4. Check that `read_ptr_grey` changes exactly one bit per read across 31 to 0. Check that `empty` is correct at pointer 16 (wrap bit set) and at 0.
- Full level: write pointer synced at gray(16), read pointer at 0. `rd_level`=16, `empty`=0 and `almost_empty`=0.
